// File: rtl/uart_tx.sv
// 8-N-1 UART transmitter with a holding register loaded independently of the frame in flight.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP (8-E-1).
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_ready_i,
    input  logic       t_byte_i,
    input  logic [7:0] din_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        bit_end;
    logic [7:0]  load_byte;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            hold_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;
        done_o    = 1'b0;
        bit_end   = (baud_q == BAUD_LAST);
        // Simultaneous load and request sends the fresh byte, not the stale holding value
        load_byte = byte_ready_i ? din_i : hold_q;
        hold_d    = byte_ready_i ? din_i : hold_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (t_byte_i) begin
                    state_d = START;
                    shift_d = load_byte;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^load_byte;
`endif
                end
            end
            START: begin
                baud_d = baud_q + 16'd1;
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_q + 16'd1;
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                baud_d = baud_q + 16'd1;
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                baud_d = baud_q + 16'd1;
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    done_o  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        // Line level is chosen from the next state so tx_o stays a plain register
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign tx_o   = tx_q;
    assign busy_o = (state_q != IDLE);

endmodule
